result_display_driver: RTL and testbench

- Sits directly downstream of the calculator's result-holding stage and consumes its 8-bit held result.
- Converts the unsigned result to three BCD digits with a sequential shift-add-3 (double-dabble) engine, one iteration per clock.
- Time-multiplexes the digits onto a shared 3-digit, active-low, seven-segment display, blanking leading zeros.

---
 rtl/result_display_driver.sv | 147 ++++++++++++++
 tb/tb_result_display_driver.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/result_display_driver.sv
// Converts the held 8-bit calculator result to BCD with a one-bit-per-clock
// double-dabble engine and scans the digits onto a 3-digit active-low display.
module result_display_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [2:0]  anode,
  output logic [6:0]  segments
);

  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned ITER_W = 3;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t              state, state_next;
  logic [7:0]          last_value, last_value_next;
  logic [7:0]          shift_reg, shift_reg_next;
  logic [11:0]         scratch, scratch_next, adj;
  logic [11:0]         bcd_next;
  logic [ITER_W-1:0]   iter, iter_next;
  logic                busy_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [1:0]          idx, idx_next;
  logic [2:0]          anode_next;
  logic [6:0]          seg_next;

  // State register plus all datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_value <= 8'd0;
      shift_reg  <= 8'd0;
      scratch    <= 12'd0;
      iter       <= '0;
      busy       <= 1'b0;
      bcd        <= 12'h000;
      cnt        <= '0;
      idx        <= 2'd0;
      anode      <= 3'b110;
      segments   <= 7'h40;
    end else begin
      state      <= state_next;
      last_value <= last_value_next;
      shift_reg  <= shift_reg_next;
      scratch    <= scratch_next;
      iter       <= iter_next;
      busy       <= busy_next;
      bcd        <= bcd_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      anode      <= anode_next;
      segments   <= seg_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (value != last_value) state_next = CONVERT;
      CONVERT: if (iter == ITER_W'(7)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction applied to every scratch nibble before the shift.
  always_comb begin
    adj = scratch;
    for (int n = 0; n < 3; n++) begin
      if (scratch[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = scratch[n*4 +: 4] + 4'd3;
    end
  end

  // Conversion datapath and published result.
  always_comb begin
    last_value_next = last_value;
    shift_reg_next  = shift_reg;
    scratch_next    = scratch;
    iter_next       = iter;
    busy_next       = busy;
    bcd_next        = bcd;
    case (state)
      IDLE: begin
        if (value != last_value) begin
          last_value_next = value;
          shift_reg_next  = value;
          scratch_next    = 12'd0;
          iter_next       = '0;
          busy_next       = 1'b1;
        end
      end
      CONVERT: begin
        {scratch_next, shift_reg_next} = {adj, shift_reg} << 1;
        iter_next = iter + ITER_W'(1);
      end
      DONE: begin
        bcd_next  = scratch;
        busy_next = 1'b0;
      end
      default: ;
    endcase
  end

  // Free-running digit scan.
  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    idx_next = idx;
    if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_next = '0;
      idx_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  // Display drive computed from next-cycle bcd/index so it always matches the registered bcd.
  always_comb begin
    anode_next = ~(3'b001 << idx_next);
    case (idx_next)
      2'd0:    seg_next = seg_of(bcd_next[3:0]);
      2'd1:    seg_next = (bcd_next[11:4] == 8'd0) ? 7'h7F : seg_of(bcd_next[7:4]);
      2'd2:    seg_next = (bcd_next[11:8] == 4'd0) ? 7'h7F : seg_of(bcd_next[11:8]);
      default: seg_next = 7'h7F;
    endcase
  end

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver with a fast scan (REFRESH_DIV = 4).
module tb_result_display_driver;

  logic        clock;
  logic        reset;
  logic [7:0]  value;
  logic        busy;
  logic [11:0] bcd;
  logic [2:0]  anode;
  logic [6:0]  segments;

  int tests  = 0;
  int failed = 0;

  result_display_driver #(.REFRESH_DIV(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .value    (value),
    .busy     (busy),
    .bcd      (bcd),
    .anode    (anode),
    .segments (segments)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive a new value; it is sampled at the next edge k. Checks busy over k..k+8 and bcd at k+9.
  task automatic run_conv(input logic [7:0] v, input logic [11:0] prev, input logic [11:0] exp);
    value = v;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("conv_busy_high", 32'(busy), 32'd1);
      if (i == 8) check("conv_bcd_hold", 32'(bcd), 32'(prev));
    end
    tick();
    check("conv_busy_low", 32'(busy), 32'd0);
    check("conv_bcd", 32'(bcd), 32'(exp));
  endtask

  // Wait (bounded) for a digit to be scanned and check its segment pattern.
  task automatic digit(input string tag, input logic [2:0] an, input logic [6:0] exp);
    for (int i = 0; i < 16; i++) begin
      if (anode === an) break;
      tick();
    end
    check({tag, "_anode"}, 32'(anode), 32'(an));
    check(tag, 32'(segments), 32'(exp));
  endtask

  logic [2:0] exp_an;

  initial begin
    reset = 1'b1;
    value = 8'd0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h000);
    check("rst_anode", 32'(anode), 32'b110);
    check("rst_seg", 32'(segments), 32'h40);
    reset = 1'b0;

    // Idle scan with value held at zero: 4 cycles per digit, only ones lit with "0".
    for (int e = 1; e <= 12; e++) begin
      tick();
      case ((e / 4) % 3)
        0:       exp_an = 3'b110;
        1:       exp_an = 3'b101;
        default: exp_an = 3'b011;
      endcase
      check("scan_anode", 32'(anode), 32'(exp_an));
      check("scan_seg", 32'(segments), (exp_an == 3'b110) ? 32'h40 : 32'h7F);
      check("idle_busy", 32'(busy), 32'd0);
    end
    check("idle_bcd", 32'(bcd), 32'h000);

    run_conv(8'd255, 12'h000, 12'h255);
    digit("d255_h", 3'b011, 7'h24);
    digit("d255_t", 3'b101, 7'h12);
    digit("d255_o", 3'b110, 7'h12);

    run_conv(8'd7, 12'h255, 12'h007);
    digit("d7_h", 3'b011, 7'h7F);
    digit("d7_t", 3'b101, 7'h7F);
    digit("d7_o", 3'b110, 7'h78);

    run_conv(8'd100, 12'h007, 12'h100);
    digit("d100_h", 3'b011, 7'h79);
    digit("d100_t", 3'b101, 7'h40);
    digit("d100_o", 3'b110, 7'h40);

    // 12 sampled at k, 34 at k+3: 34 ignored until the first conversion finishes.
    value = 8'd12;
    tick();
    check("b2b_busy_k", 32'(busy), 32'd1);
    tick();
    tick();
    value = 8'd34;
    for (int i = 3; i <= 8; i++) begin
      tick();
      check("b2b_busy_mid", 32'(busy), 32'd1);
    end
    tick();
    check("b2b_bcd_k9", 32'(bcd), 32'h012);
    check("b2b_gap", 32'(busy), 32'd0);
    for (int i = 10; i <= 18; i++) begin
      tick();
      check("b2b_busy2", 32'(busy), 32'd1);
    end
    check("b2b_bcd_k18", 32'(bcd), 32'h012);
    tick();
    check("b2b_bcd_k19", 32'(bcd), 32'h034);
    check("b2b_busy_end", 32'(busy), 32'd0);

    // Reset mid-conversion of 200, then reconversion after release.
    value = 8'd200;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'h000);
    check("mid_rst_anode", 32'(anode), 32'b110);
    check("mid_rst_seg", 32'(segments), 32'h40);
    tick();
    check("mid_rst_hold", 32'(bcd), 32'h000);
    reset = 1'b0;
    run_conv(8'd200, 12'h000, 12'h200);
    digit("d200_h", 3'b011, 7'h24);
    digit("d200_t", 3'b101, 7'h40);

    // Steady value: no further conversions.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("steady_busy", 32'(busy), 32'd0);
    end
    check("steady_bcd", 32'(bcd), 32'h200);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
